alu_req_arbiter: RTL

//  Shares one combinational 8-bit ALU instance between NUM_REQ requesters.

---
 rtl/alu_req_arbiter.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters,
// with a valid/ready response channel. Optional opcode check: ALU_ARB_OPCHECK_EN.
module alu_req_arbiter #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned ID_W     = 2,
   parameter int unsigned MUL_WAIT = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [4*NUM_REQ-1:0]       req_opcode,
   input  logic [WIDTH*NUM_REQ-1:0]   req_a,
   input  logic [WIDTH*NUM_REQ-1:0]   req_b,
   input  logic [5*NUM_REQ-1:0]       req_shift,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [ID_W-1:0]            rsp_id,
   output logic [WIDTH-1:0]           rsp_result,
   output logic                       rsp_carry,
   output logic                       rsp_zero,
   output logic                       rsp_sign,
   output logic                       rsp_err,
   output logic [3:0]                 alu_opcode,
   output logic [WIDTH-1:0]           alu_input1,
   output logic [WIDTH-1:0]           alu_input2,
   output logic [4:0]                 alu_shift,
   input  logic [WIDTH-1:0]           alu_result,
   input  logic                       alu_carry,
   input  logic                       alu_zero,
   input  logic                       alu_sign
);

   localparam int unsigned CNT_W  = (MUL_WAIT < 2) ? 1 : $clog2(MUL_WAIT + 1);
   localparam logic [3:0]  OP_MUL = 4'd10;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_RESP
   } state_t;

   state_t             state_q, state_d;
   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [3:0]         alu_opcode_q, alu_opcode_d;
   logic [WIDTH-1:0]   alu_input1_q, alu_input1_d;
   logic [WIDTH-1:0]   alu_input2_q, alu_input2_d;
   logic [4:0]         alu_shift_q, alu_shift_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0]   rsp_result_q, rsp_result_d;
   logic               rsp_carry_q, rsp_carry_d;
   logic               rsp_zero_q, rsp_zero_d;
   logic               rsp_sign_q, rsp_sign_d;
`ifdef ALU_ARB_OPCHECK_EN
   logic               rsp_err_q, rsp_err_d;
   logic               err_pend_q, err_pend_d;
   logic               op_reject;
`endif

   logic [2*NUM_REQ-1:0] dbl_valid;
   logic [NUM_REQ-1:0]   rot_valid;
   logic                 grant_found;
   int unsigned          grant_pos;
   logic [ID_W-1:0]      grant_idx;
   logic [3:0]           sel_op;
   logic [WIDTH-1:0]     sel_a;
   logic [WIDTH-1:0]     sel_b;
   logic [4:0]           sel_shift;

   // Rotate the valid vector so bit 0 is the current highest-priority requester.
   always_comb begin
      dbl_valid   = {req_valid, req_valid};
      rot_valid   = NUM_REQ'(dbl_valid >> ptr_q);
      grant_found = 1'b0;
      grant_pos   = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (!grant_found && rot_valid[k]) begin
            grant_found = 1'b1;
            grant_pos   = 32'(ptr_q) + k;
            if (grant_pos >= NUM_REQ) begin
               grant_pos = grant_pos - NUM_REQ;
            end
         end
      end
      grant_idx = ID_W'(grant_pos);
   end

   always_comb begin
      sel_op    = '0;
      sel_a     = '0;
      sel_b     = '0;
      sel_shift = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == ID_W'(i)) begin
            sel_op    = req_opcode[i*4 +: 4];
            sel_a     = req_a[i*WIDTH +: WIDTH];
            sel_b     = req_b[i*WIDTH +: WIDTH];
            sel_shift = req_shift[i*5 +: 5];
         end
      end
   end

`ifdef ALU_ARB_OPCHECK_EN
   always_comb begin
      op_reject = (sel_op == 4'd0) || (sel_op == 4'd4) || (sel_op == 4'd5) ||
                  (sel_op == 4'd11) || (sel_op[3:2] == 2'b11);
   end
`endif

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      cnt_d        = cnt_q;
      alu_opcode_d = alu_opcode_q;
      alu_input1_d = alu_input1_q;
      alu_input2_d = alu_input2_q;
      alu_shift_d  = alu_shift_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_carry_d  = rsp_carry_q;
      rsp_zero_d   = rsp_zero_q;
      rsp_sign_d   = rsp_sign_q;
`ifdef ALU_ARB_OPCHECK_EN
      rsp_err_d    = rsp_err_q;
      err_pend_d   = err_pend_q;
`endif
      req_ready    = '0;

      case (state_q)
         S_IDLE: begin
            if (grant_found) begin
               req_ready[grant_idx] = 1'b1;
               rsp_id_d = grant_idx;
               ptr_d    = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
               cnt_d    = (sel_op == OP_MUL) ? CNT_W'(MUL_WAIT) : CNT_W'(1);
               state_d  = S_EXEC;
`ifdef ALU_ARB_OPCHECK_EN
               err_pend_d = op_reject;
               if (op_reject) begin
                  cnt_d = CNT_W'(1);
               end else begin
                  alu_opcode_d = sel_op;
                  alu_input1_d = sel_a;
                  alu_input2_d = sel_b;
                  alu_shift_d  = sel_shift;
               end
`else
               alu_opcode_d = sel_op;
               alu_input1_d = sel_a;
               alu_input2_d = sel_b;
               alu_shift_d  = sel_shift;
`endif
            end
         end

         S_EXEC: begin
            if (cnt_q == CNT_W'(1)) begin
               rsp_valid_d  = 1'b1;
               state_d      = S_RESP;
               rsp_result_d = alu_result;
               rsp_carry_d  = alu_carry;
               rsp_zero_d   = alu_zero;
               rsp_sign_d   = alu_sign;
`ifdef ALU_ARB_OPCHECK_EN
               rsp_err_d    = err_pend_q;
               if (err_pend_q) begin
                  rsp_result_d = '0;
                  rsp_carry_d  = 1'b0;
                  rsp_zero_d   = 1'b0;
                  rsp_sign_d   = 1'b0;
               end
`endif
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Reset is asynchronous on every output, including this combinational one.
      if (rst) begin
         req_ready = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         ptr_q        <= '0;
         cnt_q        <= '0;
         alu_opcode_q <= '0;
         alu_input1_q <= '0;
         alu_input2_q <= '0;
         alu_shift_q  <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_result_q <= '0;
         rsp_carry_q  <= 1'b0;
         rsp_zero_q   <= 1'b0;
         rsp_sign_q   <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
         rsp_err_q    <= 1'b0;
         err_pend_q   <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         cnt_q        <= cnt_d;
         alu_opcode_q <= alu_opcode_d;
         alu_input1_q <= alu_input1_d;
         alu_input2_q <= alu_input2_d;
         alu_shift_q  <= alu_shift_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_carry_q  <= rsp_carry_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_sign_q   <= rsp_sign_d;
`ifdef ALU_ARB_OPCHECK_EN
         rsp_err_q    <= rsp_err_d;
         err_pend_q   <= err_pend_d;
`endif
      end
   end

   assign alu_opcode = alu_opcode_q;
   assign alu_input1 = alu_input1_q;
   assign alu_input2 = alu_input2_q;
   assign alu_shift  = alu_shift_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign rsp_carry  = rsp_carry_q;
   assign rsp_zero   = rsp_zero_q;
   assign rsp_sign   = rsp_sign_q;
`ifdef ALU_ARB_OPCHECK_EN
   assign rsp_err    = rsp_err_q;
`else
   assign rsp_err    = 1'b0;
`endif

endmodule
